// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scope_pkg
//  Description : Shared widths, depth and readout state encoding for the
//                capture RAM read path.
//  Revision    : 1.0  initial release
// ============================================================================
package scope_pkg;

    localparam int c_addr_width = 9;
    localparam int c_data_width = 8;
    localparam int c_depth      = 512;

    // Readout sequencer states
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

endpackage : scope_pkg
`default_nettype wire

// File: rtl/skid_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : skid_fifo2
//  Description : Two-entry register FIFO with valid/ready on both sides and
//                an occupancy count. A push into a full FIFO is accepted when
//                the head is popped on the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module skid_fifo2
    import scope_pkg::*;
#(
    parameter int WIDTH = c_data_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_in_ready  = (r_count != 2'd2) || i_out_ready;
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_data  = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;

    // Storage: write the tail slot on every accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : skid_fifo2
`default_nettype wire

// File: rtl/wave_reader.sv
`default_nettype none
// ============================================================================
//  Module      : wave_reader
//  Description : Readout sequencer for the capture RAM. Freezes acquisition,
//                reads every stored sample oldest-first starting pretrig
//                samples before the trigger, and streams them out over
//                valid/ready before releasing acquisition.
//  Revision    : 1.0  initial release
// ============================================================================
module wave_reader
    import scope_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] trig_addr,
    input  logic [ADDR_WIDTH-1:0] pretrig,
    output logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic                  r_hold;
    logic [ADDR_WIDTH-1:0] r_rdaddress;
    logic [ADDR_WIDTH-1:0] r_issue_cnt;
    logic [ADDR_WIDTH-1:0] r_out_cnt;
    logic                  r_inflight;

    logic [1:0]            w_fifo_count;
    logic                  w_fifo_valid;
    logic                  w_fifo_in_ready;
    logic                  w_xfer;
    logic [2:0]            w_pending;
    logic                  w_issue;

    // The RAM registers the address, so read data arrives exactly one cycle
    // after issue; r_inflight marks that cycle and pushes q into the FIFO.
    skid_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk         (clock),
        .rst_n       (reset_n),
        .i_in_valid  (r_inflight),
        .o_in_ready  (w_fifo_in_ready),
        .i_in_data   (q),
        .o_out_valid (w_fifo_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_count     (w_fifo_count)
    );

    assign w_xfer    = w_fifo_valid && out_ready;
    // Slots committed after this edge: the landing read plus what the FIFO
    // still holds once this cycle's transfer (if any) leaves.
    assign w_pending = {2'b00, r_inflight} + {1'b0, w_fifo_count} - {2'b00, w_xfer};
    // The in_ready term is implied by the credit check; kept as a safety guard.
    assign w_issue   = (r_state == c_st_run) && (w_pending < 3'd2) && w_fifo_in_ready;

    assign hold      = r_hold;
    assign busy      = (r_state != c_st_idle);
    assign done      = (r_state == c_st_done);
    assign rdaddress = r_rdaddress;
    assign out_valid = w_fifo_valid;
    assign out_last  = w_fifo_valid && (&r_out_cnt);

    // Sequencer FSM with read address generator and issue counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_hold      <= 1'b0;
            r_rdaddress <= '0;
            r_issue_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_rdaddress <= trig_addr - pretrig;
                        r_issue_cnt <= '0;
                        r_hold      <= 1'b1;
                        r_state     <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_issue) begin
                        r_rdaddress <= r_rdaddress + c_addr_one;
                        r_issue_cnt <= r_issue_cnt + c_addr_one;
                        if (&r_issue_cnt) r_state <= c_st_flush;
                    end
                end
                c_st_flush: begin
                    if (w_xfer && out_last) r_state <= c_st_done;
                end
                default: begin
                    r_hold  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Read-in-flight marker and delivered-sample counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
            r_out_cnt  <= '0;
        end else begin
            r_inflight <= w_issue;
            if ((r_state == c_st_idle) && start) r_out_cnt <= '0;
            else if (w_xfer)                     r_out_cnt <= r_out_cnt + c_addr_one;
        end
    end

endmodule : wave_reader
`default_nettype wire

// File: tb/tb_wave_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_reader
//  Description : Self-checking bench for wave_reader with a behavioural
//                capture RAM and a reference sample sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wave_reader;

    localparam int N = 512;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       start     = 1'b0;
    logic [8:0] trig_addr = '0;
    logic [8:0] pretrig   = '0;
    logic       out_ready = 1'b0;
    logic       hold, busy, done, out_valid, out_last;
    logic [8:0] rdaddress;
    logic [7:0] q, out_data;

    logic [7:0] mem [N];
    logic [8:0] ram_addr = '0;

    int vectors     = 0;
    int miscompares = 0;

    wave_reader #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .trig_addr (trig_addr),
        .pretrig   (pretrig),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .rdaddress (rdaddress),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    // Capture RAM read port: registered address, unregistered data
    always @(posedge clock) ram_addr <= rdaddress;
    assign q = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < N; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hold"},      32'(hold),      0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_done"},      32'(done),      0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"},  32'(out_last),  0);
        chk({tag, "_rdaddress"}, 32'(rdaddress), 0);
        chk({tag, "_out_data"},  32'(out_data),  0);
    endtask

    // One readout; negative busy_start_at / reset_at disable those events
    task automatic readout(input int trig, input int pre, input int duty,
                           input int stall_at, input int stall_len,
                           input int busy_start_at, input int reset_at);
        int         base;
        int         n;
        int         cycles;
        int         stall_left;
        bit         stalled;
        bit         pulsed;
        bit         prev_held;
        logic [7:0] prev_data;
        logic [7:0] expq[$];

        base = ((trig - pre) % N + N) % N;
        expq.delete();
        for (int k = 0; k < N; k++) expq.push_back(mem[(base + k) % N]);

        @(negedge clock);
        start     = 1'b1;
        trig_addr = 9'(trig);
        pretrig   = 9'(pre);
        out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        chk("base_addr",   32'(rdaddress), 32'(base));
        chk("e0_hold",     32'(hold),      1);
        chk("e0_busy",     32'(busy),      1);
        chk("e0_valid",    32'(out_valid), 0);
        @(negedge clock);
        chk("e1_valid",    32'(out_valid), 0);
        @(negedge clock);
        chk("e2_valid",    32'(out_valid), 1);

        n = 0; cycles = 0; stall_left = 0;
        stalled = 1'b0; pulsed = 1'b0; prev_held = 1'b0; prev_data = '0;
        while (n < N && cycles < 20000) begin
            if (!stalled && stall_len > 0 && n >= stall_at) begin
                stalled    = 1'b1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < 32'(duty));
            end
            start = 1'b0;
            if (!pulsed && busy_start_at >= 0 && n >= busy_start_at) begin
                pulsed    = 1'b1;
                start     = 1'b1;
                trig_addr = 9'(trig + 200);
                pretrig   = 9'(pre + 7);
            end
            if (reset_at >= 0 && n >= reset_at) begin
                reset_n = 1'b0;
                #1;
                chk_all_zero("midreset");
                @(negedge clock);
                reset_n = 1'b1;
                return;
            end
            chk("run_hold", 32'(hold), 1);
            chk("run_busy", 32'(busy), 1);
            chk("run_done", 32'(done), 0);
            if (prev_held) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data",  32'(out_data),  32'(prev_data));
            end
            chk("out_last", 32'(out_last), 32'(out_valid && (n == N - 1)));
            if (out_valid && out_ready) begin
                chk("sample", 32'(out_data), 32'(expq[n]));
                n++;
                prev_held = 1'b0;
            end else begin
                prev_held = out_valid;
                prev_data = out_data;
            end
            cycles++;
            @(negedge clock);
        end
        start = 1'b0;
        chk("transfers", 32'(n), N);
        if (duty == 100 && stall_len == 0) chk("consecutive", 32'(cycles), N);
        chk("done_pulse",  32'(done),      1);
        chk("done_busy",   32'(busy),      1);
        chk("done_hold",   32'(hold),      1);
        chk("done_valid",  32'(out_valid), 0);
        @(negedge clock);
        chk("after_done",  32'(done), 0);
        chk("after_busy",  32'(busy), 0);
        chk("after_hold",  32'(hold), 0);
    endtask

    initial begin
        int t;
        int p;
        fill_mem(1'b0);
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Nominal: addresses 80..511, 0..79
        readout(100, 20, 100, 0, 0, -1, -1);
        // Wrap: starts at 507
        fill_mem(1'b1);
        readout(5, 10, 100, 0, 0, -1, -1);
        // Backpressure with a 20-cycle stall
        fill_mem(1'b0);
        readout(100, 20, 30, 250, 20, -1, -1);
        // start while busy is ignored
        readout(100, 20, 70, 0, 0, 200, -1);
        // Reset mid-readout, then a clean readout from address 0
        readout(100, 20, 100, 0, 0, -1, 300);
        fill_mem(1'b1);
        readout(0, 0, 50, 0, 0, -1, -1);
        // Random trigger and pretrigger
        t = int'($urandom_range(511));
        p = int'($urandom_range(511));
        readout(t, p, 60, 100, 5, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_wave_reader
`default_nettype wire

// File: doc/wave_reader.md
# wave_reader

Readout sequencer on the read port of the 512 × 8 capture RAM. On a start request it freezes acquisition, then reads all 512 stored samples oldest-first, beginning `pretrig` samples before the trigger address. It streams them out over a valid/ready interface to the display/MCU side, then releases acquisition. It is the consumer counterpart of the free-running ADC write port.

## Interface
- `ADDR_WIDTH`, default 9: RAM address width. Depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 8: sample width.
- `clock`  in  1  single system clock. Also clocks the RAM.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `trig_addr`  in  ADDR_WIDTH  write address at the trigger. Latched on an accepted `start`.
- `pretrig`  in  ADDR_WIDTH  number of samples before the trigger to include. Latched on an accepted `start`.
- `hold`  out  1  freezes the write-address generator while high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of readout.
- `rdaddress`  out  ADDR_WIDTH  RAM read address. Registered.
- `q`  in  DATA_WIDTH  RAM read data. Valid one cycle after `rdaddress`: the address is registered at the RAM and its output is unregistered.
- `out_data`  out  DATA_WIDTH  sample.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the sample.
- `out_last`  out  1  high with the 512th sample.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- **IDLE.** On `start` high:
  - base = (trig_addr − pretrig) mod 2^ADDR_WIDTH, using plain ADDR_WIDTH-bit wrap.
  - `rdaddress` ← base, issue counter ← 0, output counter ← 0, `hold` ← 1.
  - Go to RUN.
- **RUN.** Issue one read per cycle when (reads in flight + FIFO occupancy) < 2.
  - Each issue increments `rdaddress`, wrapping 511 → 0, and increments the issue counter.
  - When the issue counter reaches 512, go to FLUSH and stop issuing.
- **Return path.** `q` is captured into a 2-entry FIFO on the cycle after its issue. `out_data` and `out_valid` come from the FIFO head.
  - Full throughput is 1 sample/cycle while `out_ready` = 1.
  - No sample is dropped or duplicated under any `out_ready` pattern.
- **Handshake.**
  - A transfer occurs when `out_valid` and `out_ready` are both high.
  - `out_valid` never drops and `out_data` never changes until the transfer.
  - `out_last` = `out_valid` and (output counter = 511).
- **FLUSH.** On the transfer with `out_last` high, go to DONE.
- **DONE.** One cycle: `done` = 1. Then go to IDLE with `hold` ← 0.
- **start outside IDLE.** Ignored. No latch, no restart.
- **pretrig = 0.** First sample is at `trig_addr`.
- **pretrig ≥ trig_addr.** Handled by the modular wrap above.
- **Reset at any time.** Return to IDLE immediately. All outputs go to 0 and the FIFO is cleared. Any partial readout is discarded.

## Timing
- **Reset values:**
  - `hold`, `busy`, `done`, `out_valid`, `out_last` = 0.
  - `rdaddress` = 0, `out_data` = 0.
- **Start latency.** Call the edge that samples `start` E0.
  - After E0: `rdaddress` = base, `hold` = `busy` = 1.
  - After E1: `q` is valid.
  - After E2: `out_valid` = 1. Sample-out latency is 2 cycles.
- **Readout length.** With `out_ready` held at 1, samples transfer on 512 consecutive cycles. `done` pulses the cycle after the last transfer, and `busy` falls the cycle after that.
- **Backpressure.** `out_ready` = 0 stalls issue within 2 cycles. Reads in flight land in the FIFO, which must never overflow.
- **hold.** Rises together with `busy` and falls with it. Writes stop from the cycle after E0.

## Structure
- Shared package `scope_pkg`:
  - `ADDR_WIDTH` / `DATA_WIDTH` defaults.
  - `DEPTH` = 512.
  - State encoding constants IDLE / RUN / FLUSH / DONE.
- One sub-module: `skid_fifo2`, a 2-entry FIFO with count and valid/ready. Its flow-control logic is reused elsewhere on the display path.
- Everything else (FSM, counters, address generator) lives in `wave_reader`.

## Test plan
- **Nominal:** trig_addr = 100, pretrig = 20, RAM preloaded with mem[i] = i[7:0], `out_ready` = 1.
  - Response: addresses 80..511 then 0..79, 512 samples in order.
  - `out_last` on the sample from address 79; `done` one cycle later.
- **Wrap:** trig_addr = 5, pretrig = 10.
  - Response: first address 507, then 508..511, 0..506.
  - Exactly 512 transfers.
- **Backpressure:** `out_ready` driven with a random 30 % duty cycle, plus a 20-cycle stall mid-stream.
  - Response: the transferred sequence matches the nominal case exactly.
  - `out_data` is stable during every stall.
- **start while busy:** pulse `start` with different `trig_addr` at transfer 200.
  - Response: ignored; the sequence and `done` are unchanged.
- **Reset mid-readout:** assert `reset_n` = 0 at transfer 300.
  - Response: all outputs are 0 immediately.
  - A subsequent `start` with trig_addr = 0, pretrig = 0 reads addresses 0..511 cleanly.
- **Latency:** the first `out_valid` appears exactly 2 cycles after the edge that samples `start`. `hold` is high throughout `busy`.
